// File: rtl/contador_secuencia.sv
// Programmable-table sequence counter: walks a run-time writable table forward or
// backward over an adjustable active length, with a registered terminal-count pulse.
module contador_secuencia #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             C,
  input  logic             NR,
  input  logic             EN,
  input  logic             DIR,
  input  logic             SCLR,
  input  logic [IDXW:0]    LEN,
  input  logic             WE,
  input  logic [IDXW-1:0]  WADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] Q,
  output logic [IDXW-1:0]  IDX,
  output logic             TC
);

  localparam logic [IDXW:0] DEPTHV = (IDXW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] tbl;
  logic [IDXW:0]               effLen;
  logic [IDXW-1:0]             last;
  logic [IDXW-1:0]             nxtIdx;
  logic                        nxtTc;
  logic                        wrHit;
  logic [WIDTH-1:0]            rdVal;

  always_comb begin
    effLen = ((LEN == '0) || (LEN > DEPTHV)) ? DEPTHV : LEN;
    last   = IDXW'(effLen - 1'b1);
    wrHit  = WE && ({1'b0, WADDR} < DEPTHV);
    nxtIdx = IDX;
    nxtTc  = 1'b0;
    if (SCLR) begin
      nxtIdx = '0;
    end else if (EN) begin
      if (DIR) begin
        if (IDX >= last) begin
          nxtIdx = '0;
          nxtTc  = 1'b1;
        end else begin
          nxtIdx = IDX + 1'b1;
        end
      end else begin
        if (IDX == '0) begin
          nxtIdx = last;
          nxtTc  = 1'b1;
        end else if (IDX > last) begin
          // length shrank under us: clamp without flagging a wrap
          nxtIdx = last;
        end else begin
          nxtIdx = IDX - 1'b1;
        end
      end
    end
    // same-edge write to the selected entry is visible immediately
    rdVal = (wrHit && (WADDR == nxtIdx)) ? WDATA : tbl[nxtIdx];
  end

  always_ff @(posedge C or negedge NR) begin
    if (!NR) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= WIDTH'(i);
      IDX <= '0;
      TC  <= 1'b0;
      Q   <= '0;
    end else begin
      if (wrHit) tbl[WADDR] <= WDATA;
      IDX <= nxtIdx;
      TC  <= nxtTc;
      Q   <= rdVal;
    end
  end

endmodule

// File: tb/tb_contador_secuencia.sv
// Bench for contador_secuencia: directed vector table, async reset corner, and
// random traffic against a rule-level model for DEPTH=8 and DEPTH=6 instances.
module tb_contador_secuencia;

  logic       C = 1'b0;
  logic       NR = 1'b0;
  logic       en = 0, dir = 0, sclr = 0, we = 0;
  logic [3:0] len = 0;
  logic [2:0] waddr = 0;
  logic [3:0] wdata = 0;
  logic [3:0] q1, q2;
  logic [2:0] idx1, idx2;
  logic       tc1, tc2;

  int nTests = 0;
  int nFail  = 0;

  contador_secuencia #(.WIDTH(4), .DEPTH(8), .IDXW(3)) u1 (
    .C(C), .NR(NR), .EN(en), .DIR(dir), .SCLR(sclr), .LEN(len),
    .WE(we), .WADDR(waddr), .WDATA(wdata), .Q(q1), .IDX(idx1), .TC(tc1));

  contador_secuencia #(.WIDTH(4), .DEPTH(6), .IDXW(3)) u2 (
    .C(C), .NR(NR), .EN(en), .DIR(dir), .SCLR(sclr), .LEN(len),
    .WE(we), .WADDR(waddr), .WDATA(wdata), .Q(q2), .IDX(idx2), .TC(tc2));

  always #5 C = ~C;

  // reference model: [0] depth 8, [1] depth 6
  int mtab [2][8];
  int midx [2];
  int mtc  [2];
  int mq   [2];
  int mdep [2] = '{8, 6};

  task automatic chk(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mtab[k][i] = i % 16;
      midx[k] = 0; mtc[k] = 0; mq[k] = 0;
    end
  endtask

  task automatic mstep(input int k);
    int dep, eff, last;
    dep = mdep[k];
    if (we && int'(waddr) < dep) mtab[k][waddr] = int'(wdata);
    eff  = (len == 0 || int'(len) > dep) ? dep : int'(len);
    last = eff - 1;
    mtc[k] = 0;
    if (sclr) midx[k] = 0;
    else if (en) begin
      if (dir) begin
        if (midx[k] >= last) begin midx[k] = 0; mtc[k] = 1; end
        else midx[k] = midx[k] + 1;
      end else begin
        if (midx[k] == 0) begin midx[k] = last; mtc[k] = 1; end
        else if (midx[k] > last) midx[k] = last;
        else midx[k] = midx[k] - 1;
      end
    end
    mq[k] = mtab[k][midx[k]];
  endtask

  task automatic cmpModel(input string tag);
    chk({tag, ".q8"},   int'(q1),   mq[0]);
    chk({tag, ".idx8"}, int'(idx1), midx[0]);
    chk({tag, ".tc8"},  int'(tc1),  mtc[0]);
    chk({tag, ".q6"},   int'(q2),   mq[1]);
    chk({tag, ".idx6"}, int'(idx2), midx[1]);
    chk({tag, ".tc6"},  int'(tc2),  mtc[1]);
  endtask

  task automatic step(input string tag);
    mstep(0);
    mstep(1);
    @(posedge C);
    #1;
    cmpModel(tag);
  endtask

  typedef struct {
    logic       en, dir, sclr, we;
    logic [3:0] len;
    logic [2:0] waddr;
    logic [3:0] wdata;
    int         q, idx, tc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic e, input logic d, input logic s, input int l,
                     input logic w, input int wa, input int wd,
                     input int q, input int idx, input int tc);
    vec_t v;
    v.en = e; v.dir = d; v.sclr = s; v.len = 4'(l);
    v.we = w; v.waddr = 3'(wa); v.wdata = 4'(wd);
    v.q = q; v.idx = idx; v.tc = tc;
    vq.push_back(v);
  endtask

  int prog [8] = '{9, 3, 12, 0, 15, 6, 1, 10};

  initial begin
    int ix;
    mreset();

    // free-run identity table
    for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 0, 0, (i+1)%8, (i+1)%8, int'(i == 7));
    // program while holding at IDX=2: Q refreshes when entry 2 is written
    for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 1, i, prog[i], (i >= 2) ? 12 : 2, 2, 0);
    add(0, 1, 1, 0, 0, 0, 0, 9, 0, 0);
    for (int i = 0; i < 9; i++) begin
      ix = (i+1)%8;
      add(1, 1, 0, 0, 0, 0, 0, prog[ix], ix, int'(i == 7));
    end
    add(0, 1, 1, 0, 0, 0, 0, 9, 0, 0);
    // backward from 0 wraps to 7
    add(1, 0, 0, 0, 0, 0, 0, 10, 7, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    add(1, 0, 0, 0, 0, 0, 0, 6, 5, 0);
    // shrink length below IDX+1 while stepping backward
    add(1, 0, 0, 3, 0, 0, 0, 12, 2, 0);
    add(1, 0, 0, 3, 0, 0, 0, 3, 1, 0);
    add(1, 0, 0, 3, 0, 0, 0, 9, 0, 0);
    add(1, 0, 0, 3, 0, 0, 0, 12, 2, 1);
    add(0, 1, 1, 5, 0, 0, 0, 9, 0, 0);
    for (int i = 0; i < 5; i++) begin
      ix = (i+1)%5;
      add(1, 1, 0, 5, 0, 0, 0, prog[ix], ix, int'(i == 4));
    end
    // LEN beyond DEPTH acts as DEPTH
    for (int i = 0; i < 8; i++) begin
      ix = (i+1)%8;
      add(1, 1, 0, 9, 0, 0, 0, prog[ix], ix, int'(i == 7));
    end
    for (int i = 0; i < 6; i++) add(1, 1, 0, 0, 0, 0, 0, prog[i+1], i+1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 0, 1, 0, 5, 5, 0, 0);
    // address 7 is real for depth 8, out of range for depth 6
    add(0, 1, 0, 0, 1, 7, 4, 5, 0, 0);

    // reset state
    @(posedge C); @(posedge C); #1;
    cmpModel("reset");
    @(negedge C); NR = 1'b1;

    foreach (vq[i]) begin
      en = vq[i].en; dir = vq[i].dir; sclr = vq[i].sclr; len = vq[i].len;
      we = vq[i].we; waddr = vq[i].waddr; wdata = vq[i].wdata;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.q", i),   int'(q1),   vq[i].q);
      chk($sformatf("vec%0d.idx", i), int'(idx1), vq[i].idx);
      chk($sformatf("vec%0d.tc", i),  int'(tc1),  vq[i].tc);
    end

    // walk u1 to IDX=4, with TC pending on u2 wrap irrelevant
    en = 1; dir = 1; sclr = 0; we = 0; len = 0;
    for (int i = 0; i < 4; i++) step("pre_rst");
    chk("pre_rst.idx", int'(idx1), 4);
    #2 NR = 1'b0;
    #1;
    mreset();
    cmpModel("async_rst");
    chk("async_rst.q", int'(q1), 0);
    #1 NR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("post_rst");
      chk("post_rst.identity", int'(q1), (i+1)%8);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      dir   = 1'($urandom_range(0, 1));
      sclr  = ($urandom_range(0, 15) == 0);
      len   = 4'($urandom_range(0, 15));
      we    = ($urandom_range(0, 2) == 0);
      waddr = 3'($urandom_range(0, 7));
      wdata = 4'($urandom_range(0, 15));
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
